// File: rtl/selecionar_ativo_pkg.sv
// Shared types and defaults for the active-node selection stage.
// Defaults match the minimum-criterion search stage.
package selecionar_ativo_pkg;

  localparam int NUM_NA_DEF         = 8;
  localparam int ADDR_WIDTH_DEF     = 8;
  localparam int CRITERIO_WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    VALID
  } estado_t;

  // all-ones criterion means "no candidate"
  function automatic logic [CRITERIO_WIDTH_DEF-1:0] criterio_invalido();
    return '1;
  endfunction

endpackage

// File: rtl/selecionar_ativo.sv
// Scans active slots for the lowest index matching the global minimum
// criterion and hands it to the expansion stage.
module selecionar_ativo
  import selecionar_ativo_pkg::*;
#(
  parameter int NUM_NA         = NUM_NA_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int CRITERIO_WIDTH = CRITERIO_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ca_pronto_in,
  input  logic [CRITERIO_WIDTH-1:0]        ca_criterio_geral_in,
  input  logic                             aa_atualizar_in,
  input  logic [NUM_NA-1:0]                na_ativo_in,
  input  logic [NUM_NA*CRITERIO_WIDTH-1:0] na_criterio_in,
  input  logic [NUM_NA*ADDR_WIDTH-1:0]     na_endereco_in,
  input  logic                             sa_aceito_in,
  output logic                             sa_valido_o,
  output logic [$clog2(NUM_NA)-1:0]        sa_indice_out,
  output logic [ADDR_WIDTH-1:0]            sa_endereco_out,
  output logic                             sa_remover_o,
  output logic                             sa_vazio_o,
  output logic                             sa_ocupado_o
);

  localparam int IW = $clog2(NUM_NA);
  localparam logic [IW-1:0] ULTIMO = IW'(NUM_NA - 1);

  estado_t                   estado;
  logic [IW-1:0]             idx;
  logic [CRITERIO_WIDTH-1:0] crit_lat;
  logic [CRITERIO_WIDTH-1:0] crit_sel;
  logic [ADDR_WIDTH-1:0]     addr_sel;
  logic                      match;

  // idx never passes ULTIMO, so the part-selects stay in range
  assign crit_sel = na_criterio_in[CRITERIO_WIDTH*idx +: CRITERIO_WIDTH];
  assign addr_sel = na_endereco_in[ADDR_WIDTH*idx +: ADDR_WIDTH];
  assign match    = na_ativo_in[idx] && (crit_sel == crit_lat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado          <= IDLE;
      idx             <= '0;
      crit_lat        <= '1;
      sa_valido_o     <= 1'b0;
      sa_indice_out   <= '0;
      sa_endereco_out <= '0;
      sa_remover_o    <= 1'b0;
      sa_vazio_o      <= 1'b0;
      sa_ocupado_o    <= 1'b0;
    end else begin
      sa_remover_o <= 1'b0;
      sa_vazio_o   <= 1'b0;
      unique case (estado)
        IDLE: begin
          if (ca_pronto_in) begin
            crit_lat     <= ca_criterio_geral_in;
            idx          <= '0;
            estado       <= SCAN;
            sa_ocupado_o <= 1'b1;
          end
        end
        SCAN: begin
          if (aa_atualizar_in) begin
            estado       <= IDLE;
            sa_ocupado_o <= 1'b0;
          end else if (ca_pronto_in) begin
            crit_lat <= ca_criterio_geral_in;
            idx      <= '0;
          end else if (match) begin
            sa_indice_out   <= idx;
            sa_endereco_out <= addr_sel;
            sa_valido_o     <= 1'b1;
            estado          <= VALID;
          end else if (idx == ULTIMO) begin
            sa_vazio_o   <= 1'b1;
            estado       <= IDLE;
            sa_ocupado_o <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        VALID: begin
          // accept wins over a concurrent rewrite of the active set
          if (sa_aceito_in) begin
            sa_valido_o  <= 1'b0;
            sa_remover_o <= 1'b1;
            estado       <= IDLE;
            sa_ocupado_o <= 1'b0;
          end else if (aa_atualizar_in) begin
            sa_valido_o  <= 1'b0;
            estado       <= IDLE;
            sa_ocupado_o <= 1'b0;
          end
        end
        default: begin
          estado       <= IDLE;
          sa_valido_o  <= 1'b0;
          sa_ocupado_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
